// File: rtl/one_wire_pkg.sv
// Shared 1-Wire definitions: 1 us based timing constants and the byte-writer state enum.
// Used by the presence waiter, reset generator, bit reader and byte writer.
package one_wire_pkg;
    localparam int T_SLOT_US        = 70;
    localparam int T_LOW1_US        = 6;
    localparam int T_LOW0_US        = 60;
    localparam int T_PRES_SAMPLE_US = 45;
    localparam int T_PRES_END_US    = 86;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SLOT   = 2'd1,
        ST_FINISH = 2'd2
    } ow_state_e;
endpackage

// File: rtl/one_wire_slot_gen.sv
// One 1-Wire write slot: slot counter, low-time compare and end-of-slot bus check.
module one_wire_slot_gen
    import one_wire_pkg::*;
#(
    parameter int T_SLOT = T_SLOT_US,
    parameter int T_LOW1 = T_LOW1_US,
    parameter int T_LOW0 = T_LOW0_US,
    parameter int CNT_W  = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_go,
    input  logic i_run,
    input  logic i_bit,
    input  logic i_bus,
    output logic o_drive_low,
    output logic o_slot_end,
    output logic o_bus_ok
);
    logic [CNT_W-1:0] r_cnt;
    logic             r_drive_low;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_t_low;

    assign w_cnt_nxt   = r_cnt + CNT_W'(1);
    assign w_t_low     = i_bit ? CNT_W'(T_LOW1) : CNT_W'(T_LOW0);
    assign o_slot_end  = i_run && (r_cnt == CNT_W'(T_SLOT - 1));
    assign o_bus_ok    = (i_bus == 1'b1);
    assign o_drive_low = r_drive_low;

    // drive_low is registered against the next count so the line follows cnt with no lag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_drive_low <= 1'b0;
        end else if (i_go) begin
            r_cnt       <= '0;
            r_drive_low <= 1'b1;
        end else if (i_run && !o_slot_end) begin
            r_cnt       <= w_cnt_nxt;
            r_drive_low <= (w_cnt_nxt < w_t_low);
        end else begin
            r_cnt       <= '0;
            r_drive_low <= 1'b0;
        end
    end
endmodule

// File: rtl/one_wire_byte_writer.sv
// Sends one byte LSB-first as eight 1-Wire write slots on an open-drain line,
// reporting done, refused start (no device) or a stuck-low bus with one-cycle pulses.
module one_wire_byte_writer
    import one_wire_pkg::*;
#(
    parameter int T_SLOT = T_SLOT_US,
    parameter int T_LOW1 = T_LOW1_US,
    parameter int T_LOW0 = T_LOW0_US,
    parameter int CNT_W  = 7
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        bus,
    input  logic       en_write,
    input  logic [7:0] data_in,
    input  logic       found_precence,
    output logic       busy,
    output logic       done_write,
    output logic       no_device,
    output logic       bus_fault
);
    ow_state_e  r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic       r_busy;
    logic       r_done;
    logic       r_no_dev;
    logic       r_fault;

    logic w_drive_low;
    logic w_slot_end;
    logic w_bus_ok;
    logic w_start_ok;
    logic w_next_bit;
    logic w_go;
    logic w_run;

    // FINISH accepts a start like IDLE so a new byte can begin on the edge after done_write
    assign w_start_ok = (r_state != ST_SLOT) && en_write && found_precence;
    assign w_next_bit = w_slot_end && w_bus_ok && (r_bit_idx != 3'd7);
    assign w_go       = w_start_ok || w_next_bit;
    assign w_run      = (r_state == ST_SLOT);

    assign bus        = w_drive_low ? 1'b0 : 1'bz;
    assign busy       = r_busy;
    assign done_write = r_done;
    assign no_device  = r_no_dev;
    assign bus_fault  = r_fault;

    one_wire_slot_gen #(
        .T_SLOT (T_SLOT),
        .T_LOW1 (T_LOW1),
        .T_LOW0 (T_LOW0),
        .CNT_W  (CNT_W)
    ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .i_go        (w_go),
        .i_run       (w_run),
        .i_bit       (r_shift[0]),
        .i_bus       (bus),
        .o_drive_low (w_drive_low),
        .o_slot_end  (w_slot_end),
        .o_bus_ok    (w_bus_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_no_dev  <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_no_dev <= 1'b0;
            r_fault  <= 1'b0;
            case (r_state)
                ST_SLOT: begin
                    if (w_slot_end) begin
                        if (!w_bus_ok) begin
                            r_fault <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (r_bit_idx == 3'd7) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_FINISH;
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    if (en_write) begin
                        if (found_precence) begin
                            r_shift   <= data_in;
                            r_bit_idx <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= ST_SLOT;
                        end else begin
                            r_no_dev <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_one_wire_byte_writer.sv
// Bench for one_wire_byte_writer: slot-level reference model checked every cycle,
// directed scenarios pinned with literal timings, then randomized traffic with device glitches.
module tb_one_wire_byte_writer;
    localparam int TS = 70;
    localparam int L1 = 6;
    localparam int L0 = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_write = 1'b0;
    logic       found_precence = 1'b0;
    logic       dev_low = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       busy, done_write, no_device, bus_fault;
    wire        bus;

    pullup (bus);
    assign bus = dev_low ? 1'b0 : 1'bz;

    one_wire_byte_writer dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .en_write       (en_write),
        .data_in        (data_in),
        .found_precence (found_precence),
        .busy           (busy),
        .done_write     (done_write),
        .no_device      (no_device),
        .bus_fault      (bus_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // observation records for the directed checks
    int widths[$];
    int done_t[$];
    int nodev_t[$];
    int fault_t[$];
    int lowrun = 0;
    int busy_cnt = 0;

    // reference model: an active transfer is (start cycle, byte); everything follows from n = cyc - e0
    bit         m_act = 0;
    int         m_e0 = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_done = 0, m_nodev = 0, m_fault = 0;

    always @(negedge clk) begin
        int n;
        bit e_drv;
        bit e_bus;
        if (rst) begin
            m_act = 0; m_done = 0; m_nodev = 0; m_fault = 0;
        end
        n = cyc - m_e0;
        e_drv = 0;
        if (m_act && n >= 0 && n < 8 * TS)
            e_drv = ((n % TS) < (m_byte[n / TS] ? L1 : L0));
        e_bus = !(e_drv || dev_low);
        chk("busy", int'(busy), int'(m_act));
        chk("done_write", int'(done_write), int'(m_done));
        chk("no_device", int'(no_device), int'(m_nodev));
        chk("bus_fault", int'(bus_fault), int'(m_fault));
        chk("bus", int'(bus === 1'b1), int'(e_bus));

        if (bus === 1'b0) lowrun++;
        else if (lowrun > 0) begin widths.push_back(lowrun); lowrun = 0; end
        if (busy) busy_cnt++;
        if (done_write) done_t.push_back(cyc);
        if (no_device) nodev_t.push_back(cyc);
        if (bus_fault) fault_t.push_back(cyc);

        m_done = 0; m_nodev = 0; m_fault = 0;
        if (!rst) begin
            if (m_act) begin
                if (n % TS == TS - 1) begin
                    if (!e_bus) begin m_act = 0; m_fault = 1; end
                    else if (n / TS == 7) begin m_act = 0; m_done = 1; end
                end
            end else if (en_write) begin
                if (found_precence) begin m_act = 1; m_e0 = cyc + 1; m_byte = data_in; end
                else m_nodev = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic start(input logic [7:0] b, input logic p, output int e);
        en_write = 1'b1; data_in = b; found_precence = p;
        @(posedge clk);
        #2;
        e = cyc;
        en_write = 1'b0;
    endtask

    task automatic clr();
        widths.delete(); done_t.delete(); nodev_t.delete(); fault_t.delete();
        busy_cnt = 0;
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        int e0;
        int exp_a5[8];
        logic [7:0] b2[2];
        exp_a5 = '{6, 60, 6, 60, 60, 6, 60, 6};
        #1 rst = 1'b1;
        repeat (3) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done_write), 0);
        chk("rst_bus", int'(bus === 1'b1), 1);
        rst = 1'b0;
        repeat (2) step();

        // 0xA5 waveform
        clr();
        start(8'hA5, 1'b1, e0);
        wait_until(e0 + 8 * TS + 10);
        chk("a5_npulse", widths.size(), 8);
        for (int i = 0; i < 8; i++) chk("a5_width", at(widths, i), exp_a5[i]);
        chk("a5_done_at", at(done_t, 0) - e0, 560);
        chk("a5_busy_cycles", busy_cnt, 560);

        // refused start
        clr();
        start(8'h3C, 1'b0, e0);
        repeat (20) step();
        chk("nodev_count", nodev_t.size(), 1);
        chk("nodev_at", at(nodev_t, 0) - e0, 0);
        chk("nodev_busy", busy_cnt, 0);
        chk("nodev_done", done_t.size(), 0);
        chk("nodev_lows", widths.size() + lowrun, 0);

        // start during a transfer is ignored
        clr();
        start(8'hFF, 1'b1, e0);
        wait_until(e0 + 99);
        en_write = 1'b1; data_in = 8'h00; found_precence = 1'b1;
        step();
        en_write = 1'b0;
        wait_until(e0 + 600);
        chk("ign_npulse", widths.size(), 8);
        for (int i = 0; i < 8; i++) chk("ign_width", at(widths, i), L1);
        chk("ign_done_count", done_t.size(), 1);

        // device holds the line low across the first slot end
        clr();
        start(8'hFF, 1'b1, e0);
        wait_until(e0 + 10);
        dev_low = 1'b1;
        wait_until(e0 + 80);
        dev_low = 1'b0;
        wait_until(e0 + 300);
        chk("flt_count", fault_t.size(), 1);
        chk("flt_at", at(fault_t, 0) - e0, 70);
        chk("flt_done", done_t.size(), 0);
        chk("flt_npulse", widths.size(), 2);
        chk("flt_w0", at(widths, 0), 6);
        chk("flt_w1", at(widths, 1), 70);
        chk("flt_busy_cycles", busy_cnt, 70);

        // reset while the line is held low
        start(8'h00, 1'b1, e0);
        wait_until(e0 + 30);
        rst = 1'b1;
        #1;
        chk("arst_bus", int'(bus === 1'b1), 1);
        chk("arst_busy", int'(busy), 0);
        repeat (3) step();
        rst = 1'b0;
        step();
        clr();
        start(8'h01, 1'b1, e0);
        wait_until(e0 + 600);
        chk("post_rst_npulse", widths.size(), 8);
        chk("post_rst_w0", at(widths, 0), 6);
        for (int i = 1; i < 8; i++) chk("post_rst_w", at(widths, i), 60);
        chk("post_rst_done", done_t.size(), 1);

        // back-to-back bytes
        clr();
        b2 = '{8'hCC, 8'h44};
        start(b2[0], 1'b1, e0);
        wait_until(e0 + 560);
        en_write = 1'b1; data_in = b2[1]; found_precence = 1'b1;
        step();
        en_write = 1'b0;
        wait_until(e0 + 561 + 600);
        chk("b2b_done_count", done_t.size(), 2);
        chk("b2b_done_gap", at(done_t, 1) - at(done_t, 0), 561);
        chk("b2b_npulse", widths.size(), 16);
        for (int i = 0; i < 16; i++)
            chk("b2b_width", at(widths, i), b2[i / 8][i % 8] ? L1 : L0);

        // randomized traffic, strobes and device glitches
        for (int it = 0; it < 12; it++) begin
            int n, f_at, f_len;
            start(8'($urandom), ($urandom_range(0, 3) != 0), e0);
            n = $urandom_range(20, 650);
            f_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 550)) : -1000;
            f_len = $urandom_range(1, 80);
            for (int k = 0; k < n; k++) begin
                if (k == f_at) dev_low = 1'b1;
                if (k == f_at + f_len) dev_low = 1'b0;
                en_write = ($urandom_range(0, 15) == 0);
                data_in = 8'($urandom);
                found_precence = ($urandom_range(0, 3) != 0);
                step();
            end
            dev_low = 1'b0;
            en_write = 1'b0;
            repeat (2) step();
        end
        repeat (700) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
